// File: rtl/ir_frame_tx.sv
// IR pulse-distance frame transmitter: leader, segment 0, link mark + gap, segment 1, end mark.
// Latency: LEAD_MARK (IR_out high) begins 3 clocks after the first clock edge that samples key_in high.
// Backpressure: none; key edges arriving while a frame is in flight are dropped, not queued.
module ir_frame_tx #(
    parameter int CLK_HZ        = 40000000,
    parameter int CARRIER_HZ    = 38000,
    parameter int SEG0_BITS     = 35,
    parameter int SEG1_BITS     = 32,
    parameter int LEAD_MARK_US  = 9000,
    parameter int LEAD_SPACE_US = 4500,
    parameter int BIT_MARK_US   = 560,
    parameter int ZERO_SPACE_US = 560,
    parameter int ONE_SPACE_US  = 1680,
    parameter int GAP_US        = 20000,
    parameter int CARRIER_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_in,
    input  logic [SEG0_BITS-1:0] IR_in_data0,
    input  logic [SEG1_BITS-1:0] IR_in_data1,
    output logic                 IR_out,
    output logic                 busy,
    output logic                 done,
    output logic                 led_out
);
    localparam int TICKS_US = CLK_HZ / 1000000;
    localparam int CARR_DIV = CLK_HZ / (2 * CARRIER_HZ);

    localparam logic [31:0] T_LEAD_MARK  = 32'(LEAD_MARK_US * TICKS_US);
    localparam logic [31:0] T_LEAD_SPACE = 32'(LEAD_SPACE_US * TICKS_US);
    localparam logic [31:0] T_BIT_MARK   = 32'(BIT_MARK_US * TICKS_US);
    localparam logic [31:0] T_ZERO       = 32'(ZERO_SPACE_US * TICKS_US);
    localparam logic [31:0] T_ONE        = 32'(ONE_SPACE_US * TICKS_US);
    localparam logic [31:0] T_GAP        = 32'(GAP_US * TICKS_US);
    localparam logic [31:0] T_CARR       = 32'(CARR_DIV);
    localparam logic [5:0]  LAST0        = 6'(SEG0_BITS - 1);
    localparam logic [5:0]  LAST1        = 6'(SEG1_BITS - 1);
    localparam logic        USE_CARR     = (CARRIER_EN != 0);

    typedef enum logic [3:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE,
        S_LINK_MARK, S_LINK_SPACE, S_END_MARK, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic                   edge_q, edge_d;
    logic [31:0]            tmr_q, tmr_d;
    logic [31:0]            carr_q, carr_d;
    logic                   carr_ph_q, carr_ph_d;
    logic [5:0]             idx_q, idx_d;
    logic                   seg_q, seg_d;
    logic [SEG0_BITS-1:0]   sh0_q, sh0_d;
    logic [SEG1_BITS-1:0]   sh1_q, sh1_d;
    logic                   led_q, led_d;
    logic                   phase_end;
    logic                   cur_bit;
    logic [5:0]             last_idx;

    function automatic logic is_mark(input state_t s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) ||
               (s == S_LINK_MARK) || (s == S_END_MARK);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            edge_q    <= 1'b0;
            tmr_q     <= '0;
            carr_q    <= '0;
            carr_ph_q <= 1'b0;
            idx_q     <= '0;
            seg_q     <= 1'b0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            edge_q    <= edge_d;
            tmr_q     <= tmr_d;
            carr_q    <= carr_d;
            carr_ph_q <= carr_ph_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            sh0_q     <= sh0_d;
            sh1_q     <= sh1_d;
            led_q     <= led_d;
        end
    end

    // Payload is held in shift registers so the current bit is always at index 0.
    assign phase_end = (tmr_q == '0);
    assign cur_bit   = seg_q ? sh1_q[0] : sh0_q[0];
    assign last_idx  = seg_q ? LAST1 : LAST0;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        edge_d  = sync2_q & ~sync3_q;
        state_d = state_q;
        tmr_d   = phase_end ? tmr_q : tmr_q - 32'd1;
        idx_d   = idx_q;
        seg_d   = seg_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        led_d   = led_q;

        case (state_q)
            S_IDLE: if (edge_q) begin
                state_d = S_LEAD_MARK;
                tmr_d   = T_LEAD_MARK - 32'd1;
                idx_d   = '0;
                seg_d   = 1'b0;
                sh0_d   = IR_in_data0;
                sh1_d   = IR_in_data1;
            end
            S_LEAD_MARK: if (phase_end) begin
                state_d = S_LEAD_SPACE;
                tmr_d   = T_LEAD_SPACE - 32'd1;
            end
            S_LEAD_SPACE: if (phase_end) begin
                state_d = S_BIT_MARK;
                tmr_d   = T_BIT_MARK - 32'd1;
            end
            S_BIT_MARK: if (phase_end) begin
                state_d = S_BIT_SPACE;
                tmr_d   = cur_bit ? T_ONE - 32'd1 : T_ZERO - 32'd1;
            end
            S_BIT_SPACE: if (phase_end) begin
                if (seg_q) sh1_d = sh1_q >> 1;
                else       sh0_d = sh0_q >> 1;
                tmr_d = T_BIT_MARK - 32'd1;
                if (idx_q == last_idx) begin
                    idx_d = '0;
                    if (!seg_q) begin
                        seg_d   = 1'b1;
                        state_d = S_LINK_MARK;
                    end else begin
                        state_d = S_END_MARK;
                    end
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_BIT_MARK;
                end
            end
            S_LINK_MARK: if (phase_end) begin
                state_d = S_LINK_SPACE;
                tmr_d   = T_GAP - 32'd1;
            end
            S_LINK_SPACE: if (phase_end) begin
                state_d = S_BIT_MARK;
                tmr_d   = T_BIT_MARK - 32'd1;
            end
            S_END_MARK: if (phase_end) begin
                state_d = S_DONE;
                led_d   = ~led_q;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Carrier restarts high at every mark entry so each mark begins with a full half-period.
        if (is_mark(state_d) && (state_d != state_q)) begin
            carr_d    = T_CARR - 32'd1;
            carr_ph_d = 1'b1;
        end else if (is_mark(state_q)) begin
            if (carr_q == '0) begin
                carr_d    = T_CARR - 32'd1;
                carr_ph_d = ~carr_ph_q;
            end else begin
                carr_d    = carr_q - 32'd1;
                carr_ph_d = carr_ph_q;
            end
        end else begin
            carr_d    = '0;
            carr_ph_d = 1'b0;
        end
    end

    always_comb begin
        IR_out  = is_mark(state_q) && (USE_CARR ? carr_ph_q : 1'b1);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        led_out = led_q;
    end
endmodule
